// File: rtl/add_tree_pipe_pkg.sv
// Shared width arithmetic and operand extension for the pipelined adder tree.
// Pure constant functions; no state. Not in the data path on its own.
package add_tree_pkg;

    // Wide enough for any legal SUM_W (32 + 4 bits).
    localparam int EXT_W = 48;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int sum_width(input int n_inputs, input int data_w);
        return data_w + clog2(n_inputs);
    endfunction

    function automatic int tree_levels(input int n_inputs);
        return clog2(n_inputs);
    endfunction

    // Operand count remaining after lvl pairwise levels (odd leftovers carried).
    function automatic int level_count(input int n_inputs, input int lvl);
        int c;
        c = n_inputs;
        for (int i = 0; i < lvl; i++) c = (c + 1) / 2;
        return c;
    endfunction

    function automatic int level_width(input int data_w, input int sum_w, input int lvl);
        return (data_w + lvl < sum_w) ? data_w + lvl : sum_w;
    endfunction

    // v holds a w-bit operand in its low bits; upper bits are filled by sign or zero.
    function automatic logic [EXT_W-1:0] extend(input logic [EXT_W-1:0] v, input int w,
                                                input bit sgn);
        logic [EXT_W-1:0] hi;
        hi = ~((EXT_W'(1) << w) - EXT_W'(1));
        if (sgn && (((v >> (w - 1)) & EXT_W'(1)) != '0)) return v | hi;
        return v & ~hi;
    endfunction

endpackage

// File: rtl/add_tree_pipe_if.sv
// Operand-vector input stream and sum output stream of the adder tree.
// master = environment side, slave = adder tree side.
interface add_tree_pipe_if
    import add_tree_pkg::*;
#(
    parameter int N_INPUTS = 3,
    parameter int DATA_W   = 8
);
    localparam int SUM_W = sum_width(N_INPUTS, DATA_W);

    logic                         in_valid;
    logic                         in_ready;
    logic [N_INPUTS*DATA_W-1:0]   in_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [SUM_W-1:0]             out_sum;

    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_sum);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_sum);
endinterface

// File: rtl/add_tree_level.sv
// One registered pairwise-reduction level: adds operands (2k, 2k+1), carries an odd leftover.
// Latency 1 cycle; holds all state (data and valid) while advance is low.
module add_tree_level
    import add_tree_pkg::*;
#(
    parameter int N_IN        = 3,
    parameter int IN_W        = 8,
    parameter int SUM_W       = 10,
    parameter int SIGNED_MODE = 0
) (
    input  logic                                                 clock,
    input  logic                                                 nrst,
    input  logic                                                 advance,
    input  logic                                                 in_vld,
    input  logic [N_IN*IN_W-1:0]                                 in_dat,
    output logic                                                 out_vld,
    output logic [((N_IN+1)/2)*level_width(IN_W, SUM_W, 1)-1:0] out_dat
);
    localparam int N_OUT = (N_IN + 1) / 2;
    localparam int OUT_W = level_width(IN_W, SUM_W, 1);

    logic [N_OUT*OUT_W-1:0] sum_dat;

    // Partial sums always fit OUT_W, so truncating the extended operand is exact.
    for (genvar k = 0; k < N_OUT; k++) begin : g_pair
        logic [OUT_W-1:0] a_dat;
        logic [OUT_W-1:0] b_dat;

        assign a_dat = OUT_W'(extend(EXT_W'(in_dat[2*k*IN_W +: IN_W]), IN_W, SIGNED_MODE != 0));

        if (2*k + 1 < N_IN) begin : g_add
            assign b_dat = OUT_W'(extend(EXT_W'(in_dat[(2*k+1)*IN_W +: IN_W]), IN_W,
                                         SIGNED_MODE != 0));
        end else begin : g_carry
            assign b_dat = '0;
        end

        assign sum_dat[k*OUT_W +: OUT_W] = a_dat + b_dat;
    end

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (advance) begin
            out_vld <= in_vld;
            out_dat <= sum_dat;
        end
    end

endmodule

// File: rtl/add_tree_pipe.sv
// Pipelined N-input adder tree: operand register followed by LEVELS pairwise levels.
// Latency LEVELS+1 cycles; whole pipe stalls together when the output is held (in_ready = advance).
module add_tree_pipe
    import add_tree_pkg::*;
#(
    parameter int N_INPUTS    = 3,
    parameter int DATA_W      = 8,
    parameter int SIGNED_MODE = 0
) (
    input  logic          clock,
    input  logic          nrst,
    add_tree_pipe_if.slave bus
);
    localparam int SUM_W  = sum_width(N_INPUTS, DATA_W);
    localparam int LEVELS = tree_levels(N_INPUTS);

    logic                       advance;
    logic                       op_vld;
    logic [N_INPUTS*DATA_W-1:0] op_dat;

    assign advance      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance;

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            op_vld <= 1'b0;
            op_dat <= '0;
        end else if (advance) begin
            op_vld <= bus.in_valid;
            op_dat <= bus.in_data;
        end
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int IN_N  = level_count(N_INPUTS, l);
        localparam int IN_W  = level_width(DATA_W, SUM_W, l);
        localparam int OUT_N = level_count(N_INPUTS, l + 1);
        localparam int OUT_W = level_width(DATA_W, SUM_W, l + 1);

        logic                   v_in;
        logic [IN_N*IN_W-1:0]   d_in;
        logic                   v_out;
        logic [OUT_N*OUT_W-1:0] d_out;

        if (l == 0) begin : g_src
            assign v_in = op_vld;
            assign d_in = op_dat;
        end else begin : g_src
            assign v_in = g_lvl[l-1].v_out;
            assign d_in = g_lvl[l-1].d_out;
        end

        add_tree_level #(
            .N_IN        (IN_N),
            .IN_W        (IN_W),
            .SUM_W       (SUM_W),
            .SIGNED_MODE (SIGNED_MODE)
        ) u_level (
            .clock   (clock),
            .nrst    (nrst),
            .advance (advance),
            .in_vld  (v_in),
            .in_dat  (d_in),
            .out_vld (v_out),
            .out_dat (d_out)
        );
    end

    assign bus.out_valid = g_lvl[LEVELS-1].v_out;
    assign bus.out_sum   = g_lvl[LEVELS-1].d_out;

endmodule
